// File: rtl/pmodad1_ctrl.sv
// PmodAD1 dual-channel 12-bit ADC conversion sequencer.
// Optional rising-threshold hit flags: define PMODAD1_HIT_DETECT_EN.
module pmodad1_ctrl #(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 2500,
  parameter int QUIET_CYCLES  = 4,
  parameter int FREE_RUN      = 1
`ifdef PMODAD1_HIT_DETECT_EN
  ,
  parameter logic [11:0] HIT_THRESH = 12'h800
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sdata0,
  input  logic        sdata1,
  output logic        cs_n,
  output logic        sclk,
  output logic        busy,
  output logic [11:0] data0,
  output logic [11:0] data1,
  output logic        valid,
  output logic        overrun
`ifdef PMODAD1_HIT_DETECT_EN
  ,
  output logic        hit0,
  output logic        hit1
`endif
);

  localparam int HCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int QCW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam int PCW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [HCW-1:0] HC_LAST = HCW'(CLK_DIV - 1);
  localparam logic [QCW-1:0] QC_LAST = QCW'(QUIET_CYCLES - 1);
  localparam logic [PCW-1:0] P_LAST  = PCW'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    QUIET
  } state_t;

  state_t         state_q;
  logic [HCW-1:0] hc_q;
  logic [3:0]     nr_q;
  logic [QCW-1:0] qc_q;
  logic [PCW-1:0] per_q;
  logic [PCW-1:0] per_d;
  logic [15:0]    sr0_q;
  logic [15:0]    sr1_q;
  logic [15:0]    nxt0;
  logic [15:0]    nxt1;
  logic [11:0]    data0_q;
  logic [11:0]    data1_q;
  logic           cs_n_q;
  logic           sclk_q;
  logic           valid_q;
  logic           tick;
  logic           trig;

  // Period tick, trigger select and next shift-register contents.
  always_comb begin
    tick  = (per_q == P_LAST);
    per_d = tick ? '0 : per_q + PCW'(1);
    trig  = (FREE_RUN != 0) ? tick : start;
    nxt0  = {sr0_q[14:0], sdata0};
    nxt1  = {sr1_q[14:0], sdata1};
  end

  // Free-running sample-period counter, independent of conversions.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_q <= '0;
    end else begin
      per_q <= per_d;
    end
  end

`ifdef PMODAD1_HIT_DETECT_EN
  logic hit0_q;
  logic hit1_q;
`endif

  // Conversion sequencer with registered pin and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hc_q    <= '0;
      nr_q    <= '0;
      qc_q    <= '0;
      sr0_q   <= '0;
      sr1_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      valid_q <= 1'b0;
`ifdef PMODAD1_HIT_DETECT_EN
      hit0_q  <= 1'b0;
      hit1_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef PMODAD1_HIT_DETECT_EN
      hit0_q  <= 1'b0;
      hit1_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          cs_n_q <= 1'b1;
          sclk_q <= 1'b1;
          if (trig) begin
            state_q <= SHIFT;
            cs_n_q  <= 1'b0;
            hc_q    <= '0;
            nr_q    <= '0;
          end
        end
        SHIFT: begin
          if (hc_q == HC_LAST) begin
            hc_q   <= '0;
            sclk_q <= ~sclk_q;
            // Sample on the rising SCLK edge.
            if (!sclk_q) begin
              sr0_q <= nxt0;
              sr1_q <= nxt1;
              nr_q  <= nr_q + 4'd1;
              if (nr_q == 4'd15) begin
                state_q <= DONE;
                cs_n_q  <= 1'b1;
                data0_q <= nxt0[11:0];
                data1_q <= nxt1[11:0];
                valid_q <= 1'b1;
`ifdef PMODAD1_HIT_DETECT_EN
                hit0_q  <= (nxt0[11:0] >= HIT_THRESH) &&
                           (data0_q < HIT_THRESH);
                hit1_q  <= (nxt1[11:0] >= HIT_THRESH) &&
                           (data1_q < HIT_THRESH);
`endif
              end
            end
          end else begin
            hc_q <= hc_q + HCW'(1);
          end
        end
        DONE: begin
          state_q <= QUIET;
          qc_q    <= '0;
        end
        QUIET: begin
          if (qc_q == QC_LAST) begin
            state_q <= IDLE;
          end else begin
            qc_q <= qc_q + QCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cs_n    = cs_n_q;
  assign sclk    = sclk_q;
  assign busy    = (state_q != IDLE);
  assign data0   = data0_q;
  assign data1   = data1_q;
  assign valid   = valid_q;
  assign overrun = trig && (state_q != IDLE);
`ifdef PMODAD1_HIT_DETECT_EN
  assign hit0    = hit0_q;
  assign hit1    = hit1_q;
`endif

endmodule

// File: tb/tb_pmodad1_ctrl.sv
// Scoreboard bench for pmodad1_ctrl: on-demand and free-running
// instances, ADC serial model, per-cycle handshake and pin checks.
module tb_pmodad1_ctrl;

  localparam int CD    = 2;
  localparam int QC    = 4;
  localparam int SP_OD = 2500;
  localparam int SP_FR = 100;
  localparam int VLAT  = 1 + 32 * CD;
  localparam int CONV  = 2 + 32 * CD + QC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  logic        rst_o, start_o, sd0_o, sd1_o;
  logic        cs_o, sclk_o, busy_o, val_o, ov_o;
  logic [11:0] d0_o, d1_o;
  logic        rst_f, start_f, sd0_f, sd1_f;
  logic        cs_f, sclk_f, busy_f, val_f, ov_f;
  logic [11:0] d0_f, d1_f;
`ifdef PMODAD1_HIT_DETECT_EN
  logic        h0_o, h1_o, h0_f, h1_f;
`endif

  pmodad1_ctrl #(
    .CLK_DIV(CD), .SAMPLE_PERIOD(SP_OD),
    .QUIET_CYCLES(QC), .FREE_RUN(0)
  ) u_od (
    .clk(clk), .rst(rst_o), .start(start_o),
    .sdata0(sd0_o), .sdata1(sd1_o),
    .cs_n(cs_o), .sclk(sclk_o), .busy(busy_o),
    .data0(d0_o), .data1(d1_o),
    .valid(val_o), .overrun(ov_o)
`ifdef PMODAD1_HIT_DETECT_EN
    , .hit0(h0_o), .hit1(h1_o)
`endif
  );

  pmodad1_ctrl #(
    .CLK_DIV(CD), .SAMPLE_PERIOD(SP_FR),
    .QUIET_CYCLES(QC), .FREE_RUN(1)
  ) u_fr (
    .clk(clk), .rst(rst_f), .start(start_f),
    .sdata0(sd0_f), .sdata1(sd1_f),
    .cs_n(cs_f), .sclk(sclk_f), .busy(busy_f),
    .data0(d0_f), .data1(d1_f),
    .valid(val_f), .overrun(ov_f)
`ifdef PMODAD1_HIT_DETECT_EN
    , .hit0(h0_f), .hit1(h1_f)
`endif
  );

  typedef struct {
    logic [11:0] d0;
    logic [11:0] d1;
    int          vc;
  } exp_t;

  exp_t        sb_o[$];
  exp_t        sb_f[$];
  logic [31:0] adc_o[$];
  logic [31:0] adc_f[$];
  logic [15:0] sh0_o, sh1_o, sh0_f, sh1_f;

  // ADC model: word loaded at CS fall, MSB driven after each SCLK fall.
  always @(negedge cs_o) begin
    if (adc_o.size() > 0) {sh0_o, sh1_o} = adc_o.pop_front();
    else {sh0_o, sh1_o} = '0;
  end
  always @(negedge sclk_o) begin
    if (cs_o === 1'b0) begin
      sd0_o = sh0_o[15];
      sd1_o = sh1_o[15];
      sh0_o = {sh0_o[14:0], 1'b0};
      sh1_o = {sh1_o[14:0], 1'b0};
    end
  end
  always @(negedge cs_f) begin
    if (adc_f.size() > 0) {sh0_f, sh1_f} = adc_f.pop_front();
    else {sh0_f, sh1_f} = '0;
  end
  always @(negedge sclk_f) begin
    if (cs_f === 1'b0) begin
      sd0_f = sh0_f[15];
      sd1_f = sh1_f[15];
      sh0_f = {sh0_f[14:0], 1'b0};
      sh1_f = {sh1_f[14:0], 1'b0};
    end
  end

  // Pin-level checker: edge counts and CS low time per conversion.
  logic pcs[2];
  logic psc[2];
  int   nr[2];
  int   nf[2];
  int   nl[2];

  task automatic edge_chk(input int i, input logic r,
                          input logic cs, input logic sc);
    if (r) begin
      nr[i] = 0;
      nf[i] = 0;
      nl[i] = 0;
    end else begin
      if (pcs[i] === 1'b0 && sc !== psc[i]) begin
        if (sc) nr[i]++;
        else nf[i]++;
      end
      if (pcs[i] === 1'b1 && cs === 1'b1)
        check("sclk_idle_high", 32'(sc), 32'd1);
      if (cs === 1'b0) nl[i]++;
      if (pcs[i] === 1'b0 && cs === 1'b1) begin
        check("sclk_rising_count", nr[i], 16);
        check("sclk_falling_count", nf[i], 16);
        check("cs_low_cycles", nl[i], 32 * CD);
        nr[i] = 0;
        nf[i] = 0;
        nl[i] = 0;
      end
    end
    pcs[i] = cs;
    psc[i] = sc;
  endtask

  always @(negedge clk) begin
    edge_chk(0, rst_o, cs_o, sclk_o);
    edge_chk(1, rst_f, cs_f, sclk_f);
  end

  // Result monitors: pop expected sample pair on each valid strobe.
  logic [11:0] hp0 = '0;
  logic [11:0] hp1 = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_o) begin
      hp0 = '0;
      hp1 = '0;
    end else if (val_o) begin
      if (sb_o.size() == 0) begin
        check("od_unexpected_valid", 32'(val_o), 32'd0);
      end else begin
        e = sb_o.pop_front();
        check("od_data0", 32'(d0_o), 32'(e.d0));
        check("od_data1", 32'(d1_o), 32'(e.d1));
        check("od_valid_cycle", cyc, e.vc);
`ifdef PMODAD1_HIT_DETECT_EN
        check("od_hit0", 32'(h0_o),
              32'(e.d0 >= 12'h800 && hp0 < 12'h800));
        check("od_hit1", 32'(h1_o),
              32'(e.d1 >= 12'h800 && hp1 < 12'h800));
        hp0 = e.d0;
        hp1 = e.d1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_f) begin
      check("fr_overrun_low", 32'(ov_f), 32'd0);
      if (val_f) begin
        if (sb_f.size() == 0) begin
          check("fr_unexpected_valid", 32'(val_f), 32'd0);
        end else begin
          e = sb_f.pop_front();
          check("fr_data0", 32'(d0_f), 32'(e.d0));
          check("fr_data1", 32'(d1_f), 32'(e.d1));
          check("fr_valid_cycle", cyc, e.vc);
        end
      end
    end
  end

  // On-demand stimulus: one cycle per call, busy/overrun model inline.
  int free_o = 0;

  task automatic od_cyc(input logic st, input logic [15:0] w0,
                        input logic [15:0] w1);
    exp_t e;
    logic bexp;
    start_o = st;
    #1;
    bexp = (cyc < free_o);
    check("od_busy", 32'(busy_o), 32'(bexp));
    check("od_overrun", 32'(ov_o), 32'(st && bexp));
    if (st && !bexp) begin
      adc_o.push_back({w0, w1});
      e.d0 = w0[11:0];
      e.d1 = w1[11:0];
      e.vc = cyc + VLAT;
      sb_o.push_back(e);
      free_o = cyc + CONV;
    end
    @(negedge clk);
  endtask

  task automatic od_idle(input int n);
    repeat (n) od_cyc(1'b0, 16'h0, 16'h0);
  endtask

  task automatic od_wait_free();
    while (cyc < free_o) od_cyc(1'b0, 16'h0, 16'h0);
  endtask

  task automatic od_conv(input logic [15:0] w0, input logic [15:0] w1);
    od_cyc(1'b1, w0, w1);
    od_wait_free();
  endtask

  task automatic od_seq();
    logic [15:0] hs [5];
    int k;
    hs[0] = 16'h0100;
    hs[1] = 16'h0900;
    hs[2] = 16'h0A00;
    hs[3] = 16'h0200;
    hs[4] = 16'h0850;
    rst_o   = 1'b1;
    start_o = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_o), 32'd1);
    check("rst_sclk", 32'(sclk_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(val_o), 32'd0);
    check("rst_overrun", 32'(ov_o), 32'd0);
    check("rst_data0", 32'(d0_o), 32'd0);
    check("rst_data1", 32'(d1_o), 32'd0);
    rst_o = 1'b0;
    od_idle(2);
    od_conv(16'h0A5C, 16'h0F00);
    od_conv(16'hF123, 16'hFFFF);
    od_idle(3);
    od_cyc(1'b1, 16'h5A5A, 16'h3C3C);
    od_idle(19);
    od_cyc(1'b1, 16'hFFFF, 16'hFFFF);
    od_wait_free();
    for (int i = 0; i < 5; i++)
      od_conv(hs[i], 16'($urandom));
    od_cyc(1'b1, 16'h0ABC, 16'h0DEF);
    od_idle(29);
    rst_o   = 1'b1;
    start_o = 1'b0;
    @(negedge clk);
    check("midrst_cs_n", 32'(cs_o), 32'd1);
    check("midrst_sclk", 32'(sclk_o), 32'd1);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_valid", 32'(val_o), 32'd0);
    check("midrst_data0", 32'(d0_o), 32'd0);
    check("midrst_data1", 32'(d1_o), 32'd0);
    @(negedge clk);
    rst_o = 1'b0;
    void'(sb_o.pop_back());
    free_o = 0;
    od_idle(80);
    for (int i = 0; i < 12; i++) begin
      od_cyc(1'b1, 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, CONV - 1);
        od_idle(k - 1);
        od_cyc(1'b1, 16'h0, 16'h0);
      end
      od_wait_free();
      od_idle($urandom_range(0, 6));
    end
    repeat (3 * CONV) od_cyc(1'b1, 16'($urandom), 16'($urandom));
    od_cyc(1'b0, 16'h0, 16'h0);
    od_wait_free();
    od_idle(5);
  endtask

  // Free-running stimulus: triggers derive from the period counter.
  task automatic fr_seq();
    exp_t e;
    int   c0;
    logic [15:0] w0;
    logic [15:0] w1;
    rst_f   = 1'b1;
    start_f = 1'b0;
    repeat (4) @(negedge clk);
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      adc_f.push_back({w0, w1});
      e.d0 = w0[11:0];
      e.d1 = w1[11:0];
      e.vc = c0 + (SP_FR - 1) + VLAT + k * SP_FR;
      sb_f.push_back(e);
    end
    rst_f = 1'b0;
    while (cyc < c0 + (SP_FR - 1) + VLAT + 4 * SP_FR + 2)
      @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sd0_o = 1'b0;
    sd1_o = 1'b0;
    sd0_f = 1'b0;
    sd1_f = 1'b0;
    sh0_o = '0;
    sh1_o = '0;
    sh0_f = '0;
    sh1_f = '0;
    fork
      od_seq();
      fr_seq();
    join
    repeat (2) @(negedge clk);
    check("od_scoreboard_drained", sb_o.size(), 0);
    check("fr_scoreboard_drained", sb_f.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
